// File: rtl/pe_mem_responder.sv
// pe_mem_responder: memory-side responder for the PE line port.
// Accepts one line read/write per mem_req_i handshake, services it from a local
// line SRAM after LATENCY clock edges and returns a one-cycle ack with read data.
//
// state  | meaning
// IDLE   | waiting for mem_req_i, request fields latched on the accepting edge
// BUSY   | access latency countdown, inputs ignored
// ACK    | one-cycle completion pulse, rdata/err valid
// DONE   | request still held after ack, waiting for mem_req_i to drop
module pe_mem_responder #(
    parameter int                    LINE_WIDTH = 256,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [LINE_WIDTH-1:0] wdata_i,
    output logic [LINE_WIDTH-1:0] rdata_o,
    output logic                  mem_ack_o,
    output logic                  mem_err_o,
    output logic                  busy_o,
    output logic [31:0]           req_count_o
);

    localparam int LINE_BYTES = LINE_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(LINE_BYTES);
    localparam int IDX_W      = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] SPAN   = (ADDR_WIDTH + 1)'(DEPTH * LINE_BYTES);
    localparam logic [3:0]          LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK, S_DONE} state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic                  r_oor;
    logic [IDX_W-1:0]      r_line;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic [LINE_WIDTH-1:0] r_rdata;
    logic                  r_ack;
    logic                  r_err;
    logic                  r_busy;
    logic [31:0]           r_count;
    logic [LINE_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] w_off;
    logic                  w_oor;
    logic [IDX_W-1:0]      w_line;
    logic                  w_wr_en;

    // Address decode: offset from the base, byte-in-line bits dropped.
    assign w_off   = addr_i - BASE_ADDR;
    assign w_oor   = (addr_i < BASE_ADDR) || ({1'b0, w_off} >= SPAN);
    assign w_line  = w_off[ADDR_LSB +: IDX_W];
    // Line write commits on the edge that enters ACK.
    assign w_wr_en = (r_state == S_BUSY) && (r_cnt == 4'd0) && r_we && !r_oor;

    // Line storage; deliberately not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_line] <= r_wdata;
        end
    end

    // Request FSM with registered ack/err/rdata/busy/count outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_oor   <= 1'b0;
            r_line  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_count <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem_req_i) begin
                        r_we    <= mem_we_i;
                        r_oor   <= w_oor;
                        r_line  <= w_line;
                        r_wdata <= wdata_i;
                        r_cnt   <= LAT_M1;
                        r_busy  <= 1'b1;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                        r_err   <= r_oor;
                        // A write ack returns the line as just written.
                        if (r_oor) begin
                            r_rdata <= '0;
                        end else if (r_we) begin
                            r_rdata <= r_wdata;
                        end else begin
                            r_rdata <= r_mem[r_line];
                        end
                        if (r_count != 32'hFFFF_FFFF) begin
                            r_count <= r_count + 32'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    if (mem_req_i) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (!mem_req_i) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rdata_o     = r_rdata;
    assign mem_ack_o   = r_ack;
    assign mem_err_o   = r_err;
    assign busy_o      = r_busy;
    assign req_count_o = r_count;

endmodule
